ex_fwd_stage: RTL and testbench

//  Parametrised execute stage for the RV32I pipeline. Successor to the fixed 4:1 execute result mux.

---
 rtl/ex_pkg.sv | 20 ++
 rtl/ex_fwd_select.sv | 43 ++++
 rtl/ex_fwd_stage.sv | 142 ++++++++++++++
 tb/tb_ex_fwd_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : ex_pkg                                                 |
// | Brief   : Shared types and widths for the RV32I execute stage.   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package ex_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Conventional meaning of the result-select codes
  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_PC4 = 2'd1,
    RES_IMM = 2'd2
  } res_sel_e;

endpackage
`default_nettype wire

// File: rtl/ex_fwd_select.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ex_fwd_select                                          |
// | Brief   : Priority forwarding resolver for one source operand.   |
// |           Lowest-index matching source wins; x0 always reads 0.  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ex_fwd_select
  import ex_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int AW      = REG_AW,
  parameter int NUM_FWD = 2
) (
  input  logic [AW-1:0]            rs_addr,
  input  logic [WIDTH-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic [NUM_FWD*AW-1:0]    fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]       fwd_rdy,
  output logic [WIDTH-1:0]         data,
  output logic                     hazard
);

  // Scan from oldest to youngest so the youngest match overwrites; a
  // non-ready winner flags a hazard without looking at older sources.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_addr[i*AW +: AW] == rs_addr)) begin
        data   = fwd_data[i*WIDTH +: WIDTH];
        hazard = ~fwd_rdy[i];
      end
    end
    if (rs_addr == '0) begin
      data   = '0;
      hazard = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_fwd_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : ex_fwd_stage                                           |
// | Brief   : Execute stage: operand forwarding, load-use stall,     |
// |           result select and EX/MEM register with handshake.      |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module ex_fwd_stage
  import ex_pkg::*;
#(
  parameter int WIDTH   = XLEN,
  parameter int AW      = REG_AW,
  parameter int NUM_FWD = 2,
  parameter int NUM_RES = 3,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic [AW-1:0]            rs1_addr,
  input  logic [AW-1:0]            rs2_addr,
  input  logic [AW-1:0]            rd_addr,
  input  logic [WIDTH-1:0]         rs1_data,
  input  logic [WIDTH-1:0]         rs2_data,
  input  logic [NUM_FWD-1:0]       fwd_we,
  input  logic [NUM_FWD*AW-1:0]    fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]       fwd_rdy,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  input  logic [NUM_RES*WIDTH-1:0] res_in,
  input  logic [SEL_W-1:0]         res_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic [WIDTH-1:0]         out_store,
  output logic [AW-1:0]            out_rd,
  output logic [CNT_W-1:0]         hazard_cnt
);

  logic             hazard_rs1;
  logic             hazard_rs2;
  logic             hazard;
  logic             fire;
  logic [WIDTH-1:0] res_mux;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [WIDTH-1:0] out_store_q,  out_store_d;
  logic [AW-1:0]    out_rd_q,     out_rd_d;
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;

  ex_fwd_select #(.WIDTH(WIDTH), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_rs1 (
    .rs_addr  (rs1_addr),
    .rf_data  (rs1_data),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .fwd_rdy  (fwd_rdy),
    .data     (op_a),
    .hazard   (hazard_rs1)
  );

  ex_fwd_select #(.WIDTH(WIDTH), .AW(AW), .NUM_FWD(NUM_FWD)) u_sel_rs2 (
    .rs_addr  (rs2_addr),
    .rf_data  (rs2_data),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .fwd_rdy  (fwd_rdy),
    .data     (op_b),
    .hazard   (hazard_rs2)
  );

  // Stall on load-use and on a full EX/MEM register that is not draining
  always_comb begin
    hazard   = in_valid && (hazard_rs1 || hazard_rs2);
    in_ready = !hazard && (!out_valid_q || out_ready);
    fire     = in_valid && in_ready;
  end

  // Result select; codes beyond the populated sources yield zero
  always_comb begin
    res_mux = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      if (res_sel == SEL_W'(i)) begin
        res_mux = res_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state of EX/MEM register (flush > fire > drain) and stall counter
  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_store_d  = out_store_q;
    out_rd_d     = out_rd_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (fire) begin
      out_valid_d  = 1'b1;
      out_result_d = res_mux;
      out_store_d  = op_b;
      out_rd_d     = rd_addr;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    hazard_cnt_d = hazard_cnt_q;
    if (hazard && (hazard_cnt_q != '1)) begin
      hazard_cnt_d = hazard_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_store_q  <= '0;
      out_rd_q     <= '0;
      hazard_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_store_q  <= out_store_d;
      out_rd_q     <= out_rd_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_store  = out_store_q;
  assign out_rd     = out_rd_q;
  assign hazard_cnt = hazard_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_fwd_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_ex_fwd_stage                                        |
// | Brief   : Directed self-checking bench for ex_fwd_stage with a   |
// |           behavioural reference model checked every cycle.       |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_ex_fwd_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NF = 2;
  localparam int NR = 3;
  localparam int SW = 2;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, flush, out_ready, out_valid;
  logic [AW-1:0] rs1_addr, rs2_addr, rd_addr, out_rd;
  logic [W-1:0]  rs1_data, rs2_data, op_a, op_b, out_result, out_store;
  logic [NF-1:0] fwd_we, fwd_rdy;
  logic [AW-1:0] fa [NF];
  logic [W-1:0]  fd [NF];
  logic [W-1:0]  ri [NR];
  logic [SW-1:0] res_sel;
  logic [CW-1:0] hazard_cnt;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*W-1:0]  fwd_data;
  logic [NR*W-1:0]  res_in;

  for (genvar g = 0; g < NF; g++) begin : g_fwd_pack
    assign fwd_addr[g*AW +: AW] = fa[g];
    assign fwd_data[g*W +: W]   = fd[g];
  end
  for (genvar g = 0; g < NR; g++) begin : g_res_pack
    assign res_in[g*W +: W] = ri[g];
  end

  ex_fwd_stage #(
    .WIDTH(W), .AW(AW), .NUM_FWD(NF), .NUM_RES(NR), .SEL_W(SW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_we(fwd_we),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_rdy(fwd_rdy),
    .op_a(op_a), .op_b(op_b), .res_in(res_in), .res_sel(res_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store(out_store), .out_rd(out_rd), .hazard_cnt(hazard_cnt)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {hazard, value} for one operand, first match from youngest
  function automatic logic [W:0] fwd_model(input logic [AW-1:0] rs, input logic [W-1:0] rf);
    if (rs == '0) return '0;
    for (int i = 0; i < NF; i++)
      if (fwd_we[i] && fa[i] == rs) return {~fwd_rdy[i], fd[i]};
    return {1'b0, rf};
  endfunction

  function automatic logic [W-1:0] res_model();
    if (int'(res_sel) < NR) return ri[res_sel];
    return '0;
  endfunction

  // Model state of the EX/MEM register
  logic          m_valid;
  logic [W-1:0]  m_res, m_store;
  logic [AW-1:0] m_rd;
  int            m_cnt;
  logic [W:0]    ma, mb;
  logic          m_hz, m_fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_res = '0; m_store = '0; m_rd = '0; m_cnt = 0;
    end else begin
      ma     = fwd_model(rs1_addr, rs1_data);
      mb     = fwd_model(rs2_addr, rs2_data);
      m_hz   = in_valid && (ma[W] || mb[W]);
      m_fire = in_valid && !m_hz && (!m_valid || out_ready);
      if (m_hz && m_cnt < (2**CW) - 1) m_cnt++;
      if (m_fire && !flush) begin
        m_res = res_model(); m_store = mb[W-1:0]; m_rd = rd_addr;
      end
      if (flush)                     m_valid = 1'b0;
      else if (m_fire)               m_valid = 1'b1;
      else if (m_valid && out_ready) m_valid = 1'b0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  logic [W:0] ca, cb;
  logic       c_hz;
  always @(negedge clk) begin
    ca   = fwd_model(rs1_addr, rs1_data);
    cb   = fwd_model(rs2_addr, rs2_data);
    c_hz = in_valid && (ca[W] || cb[W]);
    chk("m_op_a",     op_a, ca[W-1:0]);
    chk("m_op_b",     op_b, cb[W-1:0]);
    chk("m_in_ready", 32'(in_ready), 32'(!c_hz && (!m_valid || out_ready)));
    chk("m_valid",    32'(out_valid), 32'(m_valid));
    chk("m_result",   out_result, m_res);
    chk("m_store",    out_store, m_store);
    chk("m_rd",       32'(out_rd), 32'(m_rd));
    chk("m_hcnt",     32'(hazard_cnt), 32'(m_cnt));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; flush = 0; out_ready = 1; rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    rs1_data = 32'h1111_0001; rs2_data = 32'h2222_0002;
    fwd_we = '0; fwd_rdy = '1; res_sel = 0;
    for (int i = 0; i < NF; i++) begin fa[i] = '0; fd[i] = '0; end
    for (int i = 0; i < NR; i++) ri[i] = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_hcnt",  32'(hazard_cnt), 32'd0);
    chk("rst_res",   out_result, 32'd0);
    step(2);
    rst_n = 1;

    // Youngest matching source wins over older one
    rs1_addr = 5; fa[0] = 5; fd[0] = 32'hAA; fa[1] = 5; fd[1] = 32'hBB;
    fwd_we = 2'b11; fwd_rdy = 2'b11;
    #1 chk("t1_op_a", op_a, 32'hAA);

    // x0 reads zero even with a forwarding match
    fa[0] = 0; fd[0] = 32'h1234; rs2_addr = 0; rs2_data = 32'hDEAD;
    #1 chk("t2_op_b", op_b, 32'h0);
    chk("t2_op_a", op_a, 32'hBB);

    // A simple fire: result from ALU slot
    in_valid = 1; ri[0] = 32'h111; ri[1] = 32'h444; ri[2] = 32'h888; rd_addr = 3;
    step(1);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_res",   out_result, 32'h111);
    chk("t2_rd",    32'(out_rd), 32'd3);

    // Load-use stall for two cycles then fire
    rs1_addr = 7; fa[0] = 7; fd[0] = 32'h77; fwd_we = 2'b01; fwd_rdy = 2'b00; rd_addr = 9;
    #1 chk("t3_rdy0", 32'(in_ready), 32'd0);
    step(1);
    chk("t3_rdy1", 32'(in_ready), 32'd0);
    step(1);
    chk("t3_hcnt", 32'(hazard_cnt), 32'd2);
    fwd_rdy = 2'b01;
    #1 chk("t3_rdy2", 32'(in_ready), 32'd1);
    chk("t3_op_a", op_a, 32'h77);
    step(1);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_rd",    32'(out_rd), 32'd9);

    // Out-of-range select yields zero
    res_sel = 3; rd_addr = 4;
    step(1);
    chk("t4_res",   out_result, 32'h0);
    chk("t4_valid", 32'(out_valid), 32'd1);

    // Backpressure holds outputs and blocks input
    out_ready = 0; res_sel = 1; rd_addr = 6;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("t5_hold_v",   32'(out_valid), 32'd1);
      chk("t5_hold_res", out_result, 32'h0);
      chk("t5_hold_rd",  32'(out_rd), 32'd4);
      chk("t5_hold_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1;
    step(1);
    chk("t5_b2b0", out_result, 32'h444);
    res_sel = 2;
    step(1);
    chk("t5_b2b1", out_result, 32'h888);
    chk("t5_b2bv", 32'(out_valid), 32'd1);

    // Flush together with fire drops the instruction, data held
    flush = 1; res_sel = 0;
    step(1);
    chk("t6_flush_v",   32'(out_valid), 32'd0);
    chk("t6_flush_res", out_result, 32'h888);
    flush = 0;

    // Long stall saturates the counter at 7
    fwd_rdy = 2'b00;
    step(7);
    chk("t6_sat", 32'(hazard_cnt), 32'd7);

    // Asynchronous reset mid-stall
    #2 rst_n = 0;
    #1;
    chk("t6_arst_v",   32'(out_valid), 32'd0);
    chk("t6_arst_res", out_result, 32'd0);
    chk("t6_arst_st",  out_store, 32'd0);
    chk("t6_arst_rd",  32'(out_rd), 32'd0);
    chk("t6_arst_cnt", 32'(hazard_cnt), 32'd0);
    step(1);
    in_valid = 0;
    rst_n = 1;
    step(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
